// File: rtl/pipe_pkg.sv
// Shared defaults, depth limits and count-width helper for the register chain.
// No logic; imported by the chain top and its stage slot.
package pipe_pkg;

    localparam int PIPE_WIDTH_DEF = 32;
    localparam int PIPE_DEPTH_DEF = 2;
    localparam int PIPE_DEPTH_MIN = 1;
    localparam int PIPE_DEPTH_MAX = 16;

    // Bits needed to represent an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline stage: a valid bit plus a data register with load/advance control.
// Latency: 1 cycle from load to v/d. Backpressure: holds its word while neither loaded nor advanced.
// Flush drops the valid bit but leaves the data register untouched.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Flush,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             advance,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            v <= 1'b0;
            d <= RESET_VALUE;
        end else begin
            if (load && !Flush) begin
                d <= load_dat;
            end
            // A reload wins over an advance, so a word moving out is replaced in place.
            if (Flush) begin
                v <= 1'b0;
            end else if (load) begin
                v <= 1'b1;
            end else if (advance) begin
                v <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Valid/ready register chain of DEPTH stages with bubble collapse and flush.
// Latency: DEPTH cycles push-to-output; one word per cycle with Out_Ready high.
// Backpressure: stalls only stages whose successor is full and not moving; In_Ready is combinational.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = PIPE_WIDTH_DEF,
    parameter int               DEPTH       = PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Flush,
    input  logic                          In_Valid,
    input  logic [WIDTH-1:0]              In_Data,
    output logic                          In_Ready,
    output logic                          Out_Valid,
    output logic [WIDTH-1:0]              Out_Data,
    input  logic                          Out_Ready,
    output logic [count_width(DEPTH)-1:0] Count
);

    localparam int CW = count_width(DEPTH);

    if (DEPTH < PIPE_DEPTH_MIN || DEPTH > PIPE_DEPTH_MAX) begin : g_depth_err
        $error("pipe_reg_chain: DEPTH out of range");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] mv;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] d [DEPTH];
    logic             push;

    // Advance resolves from the output side back toward the input side.
    always_comb begin
        logic carry;
        mv           = '0;
        carry        = v[DEPTH-1] && Out_Ready;
        mv[DEPTH-1]  = carry;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            carry = v[i] && (!v[i+1] || carry);
            mv[i] = carry;
        end
    end

    assign In_Ready = !Flush && (!v[0] || mv[0]);
    assign push     = In_Valid && In_Ready;

    always_comb begin
        load    = '0;
        load[0] = push;
        for (int i = 1; i < DEPTH; i++) begin
            load[i] = mv[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [WIDTH-1:0] src;
        if (g == 0) begin : g_head
            assign src = In_Data;
        end else begin : g_body
            assign src = d[g-1];
        end

        pipe_slot #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_slot (
            .Clk      (Clk),
            .Rst      (Rst),
            .Flush    (Flush),
            .load     (load[g]),
            .load_dat (src),
            .advance  (mv[g]),
            .v        (v[g]),
            .d        (d[g])
        );
    end

    assign Out_Valid = v[DEPTH-1];
    assign Out_Data  = d[DEPTH-1];

    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            acc = acc + CW'(v[i]);
        end
        Count = acc;
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: vector table on DEPTH=2, directed corners on DEPTH=3,
// random traffic with a scoreboard on DEPTH=1 and DEPTH=4.
module tb_pipe_reg_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // DEPTH=2, RESET_VALUE=0
    logic rst_2, flush_2, iv_2, ir_2, ov_2, ordy_2;
    logic [15:0] id_2, od_2;
    logic [1:0]  cnt_2;
    // DEPTH=3, RESET_VALUE=5
    logic rst_3, flush_3, iv_3, ir_3, ov_3, ordy_3;
    logic [15:0] id_3, od_3;
    logic [1:0]  cnt_3;
    // DEPTH=1
    logic rst_1, flush_1, iv_1, ir_1, ov_1, ordy_1;
    logic [15:0] id_1, od_1;
    logic [0:0]  cnt_1;
    // DEPTH=4
    logic rst_4, flush_4, iv_4, ir_4, ov_4, ordy_4;
    logic [15:0] id_4, od_4;
    logic [2:0]  cnt_4;

    pipe_reg_chain #(.WIDTH(16), .DEPTH(2), .RESET_VALUE(16'h0000)) u_d2 (
        .Clk(clk), .Rst(rst_2), .Flush(flush_2), .In_Valid(iv_2), .In_Data(id_2),
        .In_Ready(ir_2), .Out_Valid(ov_2), .Out_Data(od_2), .Out_Ready(ordy_2), .Count(cnt_2));
    pipe_reg_chain #(.WIDTH(16), .DEPTH(3), .RESET_VALUE(16'h0005)) u_d3 (
        .Clk(clk), .Rst(rst_3), .Flush(flush_3), .In_Valid(iv_3), .In_Data(id_3),
        .In_Ready(ir_3), .Out_Valid(ov_3), .Out_Data(od_3), .Out_Ready(ordy_3), .Count(cnt_3));
    pipe_reg_chain #(.WIDTH(16), .DEPTH(1), .RESET_VALUE(16'h0000)) u_d1 (
        .Clk(clk), .Rst(rst_1), .Flush(flush_1), .In_Valid(iv_1), .In_Data(id_1),
        .In_Ready(ir_1), .Out_Valid(ov_1), .Out_Data(od_1), .Out_Ready(ordy_1), .Count(cnt_1));
    pipe_reg_chain #(.WIDTH(16), .DEPTH(4), .RESET_VALUE(16'h0000)) u_d4 (
        .Clk(clk), .Rst(rst_4), .Flush(flush_4), .In_Valid(iv_4), .In_Data(id_4),
        .In_Ready(ir_4), .Out_Valid(ov_4), .Out_Data(od_4), .Out_Ready(ordy_4), .Count(cnt_4));

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        chk;
        logic        ir;
        logic        ov;
        logic [15:0] od;
        logic [1:0]  cnt;
    } vec_t;

    vec_t tbl [14];

    logic [15:0] q1 [$];
    logic [15:0] q3 [$];
    logic [15:0] q4 [$];

    logic        s_ir, s_ov;
    logic [15:0] s_od;
    int          s_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard step for one chain, sampled mid-cycle before the edge commits.
    task automatic sb(input int k, input logic r, input logic f, input logic v, input logic ir,
                      input logic ov, input logic rd, input logic [15:0] dat,
                      input logic [15:0] od, input int cnt, input string tag);
        int occ;
        logic [15:0] exp_w;
        case (k)
            1:       occ = q1.size();
            3:       occ = q3.size();
            default: occ = q4.size();
        endcase
        check({tag, "_count"}, cnt, occ);
        if (r) begin
            case (k)
                1:       q1.delete();
                3:       q3.delete();
                default: q4.delete();
            endcase
        end else begin
            if (f) check({tag, "_in_ready_flush"}, {31'd0, ir}, 32'd0);
            if (ov && rd) begin
                if (occ == 0) begin
                    check({tag, "_unexpected_out_valid"}, {31'd0, ov}, 32'd0);
                end else begin
                    case (k)
                        1:       exp_w = q1.pop_front();
                        3:       exp_w = q3.pop_front();
                        default: exp_w = q4.pop_front();
                    endcase
                    check({tag, "_data"}, {16'd0, od}, {16'd0, exp_w});
                end
            end
            if (v && ir) begin
                case (k)
                    1:       q1.push_back(dat);
                    3:       q3.push_back(dat);
                    default: q4.push_back(dat);
                endcase
            end
            if (f) begin
                case (k)
                    1:       q1.delete();
                    3:       q3.delete();
                    default: q4.delete();
                endcase
            end
        end
    endtask

    task automatic step3(input logic r, input logic f, input logic v, input logic [15:0] dat,
                         input logic rd);
        rst_3 = r; flush_3 = f; iv_3 = v; id_3 = dat; ordy_3 = rd;
        @(negedge clk);
        s_ir  = ir_3;
        s_ov  = ov_3;
        s_od  = od_3;
        s_cnt = int'(cnt_3);
        sb(3, r, f, v, ir_3, ov_3, rd, dat, od_3, int'(cnt_3), "d3");
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rst   iv    id      ordy  chk   ir    ov    od      cnt
        tbl[0]  = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 16'hA, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 2'd0};
        tbl[2]  = '{1'b0, 1'b1, 16'hB, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 2'd1};
        tbl[3]  = '{1'b0, 1'b1, 16'hC, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA, 2'd2};
        tbl[4]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hB, 2'd2};
        tbl[5]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hC, 2'd1};
        tbl[6]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'hC, 2'd0};
        tbl[7]  = '{1'b0, 1'b1, 16'hD, 1'b0, 1'b1, 1'b1, 1'b0, 16'hC, 2'd0};
        tbl[8]  = '{1'b0, 1'b1, 16'hE, 1'b0, 1'b1, 1'b1, 1'b0, 16'hC, 2'd1};
        tbl[9]  = '{1'b0, 1'b1, 16'hF, 1'b0, 1'b1, 1'b0, 1'b1, 16'hD, 2'd2};
        tbl[10] = '{1'b0, 1'b1, 16'hF, 1'b1, 1'b1, 1'b1, 1'b1, 16'hD, 2'd2};
        tbl[11] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hE, 2'd2};
        tbl[12] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hF, 2'd1};
        tbl[13] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'hF, 2'd0};

        rst_2 = 1; flush_2 = 0; iv_2 = 0; id_2 = 0; ordy_2 = 0;
        rst_3 = 1; flush_3 = 0; iv_3 = 0; id_3 = 0; ordy_3 = 0;
        rst_1 = 1; flush_1 = 0; iv_1 = 0; id_1 = 0; ordy_1 = 0;
        rst_4 = 1; flush_4 = 0; iv_4 = 0; id_4 = 0; ordy_4 = 0;
        repeat (3) @(posedge clk);
        #1;

        // DEPTH=2 vector table: latency, throughput, stall, full push+pop
        for (int i = 0; i < 14; i++) begin
            rst_2 = tbl[i].rst; iv_2 = tbl[i].iv; id_2 = tbl[i].id; ordy_2 = tbl[i].ordy;
            flush_2 = 1'b0;
            @(negedge clk);
            if (tbl[i].chk) begin
                check($sformatf("d2_row%0d_in_ready", i), {31'd0, ir_2}, {31'd0, tbl[i].ir});
                check($sformatf("d2_row%0d_out_valid", i), {31'd0, ov_2}, {31'd0, tbl[i].ov});
                check($sformatf("d2_row%0d_out_data", i), {16'd0, od_2}, {16'd0, tbl[i].od});
                check($sformatf("d2_row%0d_count", i), {30'd0, cnt_2}, {30'd0, tbl[i].cnt});
            end
            @(posedge clk);
            #1;
        end

        // DEPTH=3 reset state with RESET_VALUE=5
        step3(1, 0, 0, 16'h0, 0);
        step3(0, 0, 0, 16'h0, 0);
        check("d3_reset_out_data", {16'd0, s_od}, 32'h5);
        check("d3_reset_out_valid", {31'd0, s_ov}, 32'd0);
        check("d3_reset_count", s_cnt, 32'd0);
        check("d3_reset_in_ready", {31'd0, s_ir}, 32'd1);

        // Fill with output blocked, then release: 4th word enters with first pop
        step3(0, 0, 1, 16'h11, 0);
        step3(0, 0, 1, 16'h12, 0);
        step3(0, 0, 1, 16'h13, 0);
        step3(0, 0, 1, 16'h14, 0);
        check("d3_full_in_ready", {31'd0, s_ir}, 32'd0);
        check("d3_full_count", s_cnt, 32'd3);
        step3(0, 0, 1, 16'h14, 1);
        check("d3_push_with_pop_in_ready", {31'd0, s_ir}, 32'd1);
        repeat (4) step3(0, 0, 0, 16'h0, 1);

        // Bubble collapse behind a stalled output word
        step3(0, 0, 1, 16'h21, 0);
        step3(0, 0, 0, 16'h0, 0);
        step3(0, 0, 0, 16'h0, 0);
        step3(0, 0, 1, 16'h22, 0);
        check("d3_bubble1_in_ready", {31'd0, s_ir}, 32'd1);
        check("d3_bubble1_count", s_cnt, 32'd1);
        step3(0, 0, 1, 16'h23, 0);
        check("d3_bubble2_in_ready", {31'd0, s_ir}, 32'd1);
        check("d3_bubble2_count", s_cnt, 32'd2);
        step3(0, 0, 1, 16'h24, 0);
        check("d3_bubble3_in_ready", {31'd0, s_ir}, 32'd0);
        check("d3_bubble3_count", s_cnt, 32'd3);

        // Flush on a full chain while popping and offering input
        step3(0, 1, 1, 16'h25, 1);
        check("d3_flush_in_ready", {31'd0, s_ir}, 32'd0);
        step3(0, 0, 0, 16'h0, 0);
        check("d3_after_flush_count", s_cnt, 32'd0);
        check("d3_after_flush_out_valid", {31'd0, s_ov}, 32'd0);
        check("d3_after_flush_data_kept", {16'd0, s_od}, 32'h21);

        // Rst together with Flush mid-stream
        step3(0, 0, 1, 16'h31, 0);
        step3(0, 0, 1, 16'h32, 0);
        step3(0, 0, 1, 16'h33, 0);
        step3(1, 1, 1, 16'h34, 1);
        step3(0, 0, 0, 16'h0, 0);
        check("d3_rst_flush_out_data", {16'd0, s_od}, 32'h5);
        check("d3_rst_flush_out_valid", {31'd0, s_ov}, 32'd0);
        check("d3_rst_flush_count", s_cnt, 32'd0);
        check("d3_rst_flush_in_ready", {31'd0, s_ir}, 32'd1);

        // Random traffic on DEPTH=1 and DEPTH=4
        rst_1 = 0; rst_4 = 0;
        for (int c = 0; c < 10000; c++) begin
            int pr;
            pr = ((c / 700) % 3 == 0) ? 25 : (((c / 700) % 3 == 1) ? 60 : 95);
            iv_1   = ($urandom_range(0, 99) < 60);
            id_1   = 16'($urandom);
            ordy_1 = ($urandom_range(0, 99) < pr);
            iv_4   = ($urandom_range(0, 99) < 65);
            id_4   = 16'($urandom);
            ordy_4 = ($urandom_range(0, 99) < 120 - pr);
            @(negedge clk);
            sb(1, 0, 0, iv_1, ir_1, ov_1, ordy_1, id_1, od_1, int'(cnt_1), "d1");
            sb(4, 0, 0, iv_4, ir_4, ov_4, ordy_4, id_4, od_4, int'(cnt_4), "d4");
            @(posedge clk);
            #1;
        end
        iv_1 = 0; ordy_1 = 1; iv_4 = 0; ordy_4 = 1;
        repeat (8) begin
            @(negedge clk);
            sb(1, 0, 0, iv_1, ir_1, ov_1, ordy_1, id_1, od_1, int'(cnt_1), "d1");
            sb(4, 0, 0, iv_4, ir_4, ov_4, ordy_4, id_4, od_4, int'(cnt_4), "d4");
            @(posedge clk);
            #1;
        end
        check("d1_drained", q1.size(), 32'd0);
        check("d4_drained", q4.size(), 32'd0);
        check("d4_final_out_valid", {31'd0, ov_4}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; legal range >= 1.
REQ-002 Parameter DEPTH, default 2, number of register stages; legal range 1..16.
REQ-003 Parameter RESET_VALUE, default 0, WIDTH-bit value loaded into every stage data register on reset.
REQ-004 Clk  input  1  single clock; all state changes on rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 Flush  input  1  synchronous pipeline clear (bubble insertion).
REQ-007 In_Valid  input  1  upstream word present on In_Data.
REQ-008 In_Data  input  WIDTH  upstream word.
REQ-009 In_Ready  output  1  chain accepts In_Data this cycle.
REQ-010 Out_Valid  output  1  Out_Data holds a valid word.
REQ-011 Out_Data  output  WIDTH  data of last stage.
REQ-012 Out_Ready  input  1  downstream accepts Out_Data this cycle.
REQ-013 Count  output  clog2(DEPTH+1)  number of stages currently holding valid words.

Function
REQ-014 Stage i (0 = input side, DEPTH-1 = output side) SHALL hold one valid bit v[i] and one WIDTH-bit data register d[i].
REQ-015 Output transfer pop SHALL = Out_Valid && Out_Ready; input transfer push SHALL = In_Valid && In_Ready.
REQ-016 Stage DEPTH-1 SHALL advance (mv) when pop; stage i < DEPTH-1 SHALL advance when v[i] && (!v[i+1] || mv[i+1]).
REQ-017 In_Ready SHALL = !Flush && (!v[0] || mv[0]), combinational; bubbles collapse, so a stalled output does not stall an upstream stage that has an empty successor.
REQ-018 On an edge where stage i+1 loads from stage i, d[i+1] <= d[i] and v[i+1] <= 1; a stage that advances and is not reloaded SHALL clear its valid bit.
REQ-019 On push, d[0] <= In_Data and v[0] <= 1.
REQ-020 A stage neither loading nor advancing SHALL hold d and v unchanged (stall).
REQ-021 Out_Valid SHALL = v[DEPTH-1]; Out_Data SHALL = d[DEPTH-1]; both registered, no combinational path from In_Data.
REQ-022 Minimum latency SHALL be DEPTH cycles: word pushed at edge k appears on Out_Data/Out_Valid after edge k+DEPTH-1, given no stalls.
REQ-023 Throughput SHALL be one word per cycle when Out_Ready is held high.
REQ-024 Word order SHALL be preserved; no word duplicated or dropped except by Flush/Rst.
REQ-025 Flush SHALL clear all v[i] at the next edge; d[i] SHALL remain unchanged; In_Ready SHALL be 0 during the Flush cycle.
REQ-026 Pop in a Flush cycle SHALL still count as a completed transfer (downstream keeps the word).
REQ-027 Count SHALL equal the population count of v[] (registered values), range 0..DEPTH.
REQ-028 Simultaneous push and pop on a full chain SHALL be accepted in the same cycle; Count unchanged.

Reset
REQ-029 Rst SHALL take priority over Flush and all handshakes.
REQ-030 On Rst at an edge: all v[i] <= 0, all d[i] <= RESET_VALUE; hence Out_Valid=0, Out_Data=RESET_VALUE, Count=0, In_Ready=1 after release.
REQ-031 Rst asserted mid-stream SHALL discard all held words; no partial transfer completes.

Structure
REQ-032 Shared package pipe_pkg SHALL hold the WIDTH/DEPTH defaults, DEPTH limits, and the clog2 count-width function.
REQ-033 One sub-module pipe_slot (one stage: v, d, load/advance logic) SHALL be instantiated DEPTH times via generate.

Verification
REQ-034 Rst, then push 0xA, 0xB, 0xC with Out_Ready=1, DEPTH=2 -> outputs 0xA, 0xB, 0xC on consecutive cycles, first 2 cycles after first push, Count max 2.
REQ-035 DEPTH=3, Out_Ready=0, push 4 words -> first 3 accepted, In_Ready=0 at 4th, Count=3; raise Out_Ready -> 4th accepted same cycle as first pop.
REQ-036 DEPTH=3, one word in stage 2 stalled, v[0]=v[1]=0 -> push accepted each cycle until full (bubble collapse), Count 1->2->3.
REQ-037 Chain full (Count=3), Flush=1 with Out_Ready=1 and In_Valid=1 -> output word consumed, input rejected, next cycle Count=0, Out_Valid=0, d unchanged.
REQ-038 Rst and Flush asserted together mid-stream, RESET_VALUE=0x5 -> next cycle Out_Data=0x5, Out_Valid=0, Count=0, In_Ready=1.
REQ-039 Random In_Valid/Out_Ready 10k cycles, DEPTH=1 and 4 -> scoreboard order match, no loss, Count equals scoreboard occupancy every cycle.
